// File: rtl/time_display_driver.sv
// Time-word to 4-digit multiplexed 7-segment driver: sequential binary-to-BCD
// conversion of the selected field pair, atomic digit commit, free-running scan.
module time_display_driver #(
    parameter int unsigned SCAN_DIV = 1
) (
    input  logic        kh_clk,
    input  logic        reset_n,
    input  logic [26:0] disp_time,
    input  logic        sel_hm,
    input  logic        show_12,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONV_HI = 2'd1,
        CONV_LO = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_start;

    logic [14:0] r_key;
    logic        r_pend;
    logic [5:0]  r_val;
    logic [3:0]  r_tens;
    logic [2:0]  r_cnt;
    logic [5:0]  r_lo_in;
    logic [3:0]  r_hi_t;
    logic [3:0]  r_hi_o;
    logic        r_valid_pend;
    logic        r_colon_pend;
    logic [3:0]  r_dig3;
    logic [3:0]  r_dig2;
    logic [3:0]  r_dig1;
    logic [3:0]  r_dig0;
    logic        r_valid;
    logic        r_colon;
    logic        r_busy;

    logic [7:0]  r_div;
    logic [1:0]  r_idx;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp;

    logic [4:0]  w_hr;
    logic [5:0]  w_min;
    logic [5:0]  w_sec;
    logic        w_unused_ms;
    logic [5:0]  w_hi_field;
    logic [5:0]  w_lo_field;
    logic [5:0]  w_hi_val;
    logic [14:0] w_key;
    logic        w_valid;
    logic        w_colon;
    logic        w_ge10;
    logic [5:0]  w_val_step;
    logic [3:0]  w_tens_step;
    logic        w_last_step;

    assign w_hr        = disp_time[26:22];
    assign w_min       = disp_time[21:16];
    assign w_sec       = disp_time[15:10];
    assign w_unused_ms = ^disp_time[9:0];

    // sec[0] joins the key in HH:MM mode only, so the colon blink re-commits there
    assign w_hi_field = sel_hm ? {1'b0, w_hr} : w_min;
    assign w_lo_field = sel_hm ? w_min : w_sec;
    assign w_key      = {sel_hm, show_12, w_hi_field, w_lo_field, sel_hm & w_sec[0]};
    assign w_valid    = sel_hm ? ((w_hr <= 5'd23) && (w_min <= 6'd59))
                               : ((w_min <= 6'd59) && (w_sec <= 6'd59));
    assign w_hi_val   = (sel_hm && show_12 && (w_hr == 5'd0)) ? 6'd12 : w_hi_field;
    assign w_colon    = sel_hm ? ~w_sec[0] : 1'b1;

    assign w_ge10      = (r_val >= 6'd10);
    assign w_val_step  = w_ge10 ? (r_val - 6'd10) : r_val;
    assign w_tens_step = w_ge10 ? (r_tens + 4'd1) : r_tens;
    assign w_last_step = (r_cnt == 3'd5);

    // FSM state register
    always_ff @(posedge kh_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state; the IDLE cycle holding r_pend is the latch cycle
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend) begin
                    w_state_nxt = CONV_HI;
                end else if (w_key != r_key) begin
                    w_start = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CONV_HI: begin
                if (w_last_step) begin
                    w_state_nxt = CONV_LO;
                end else begin
                    w_state_nxt = CONV_HI;
                end
            end
            CONV_LO: begin
                if (w_last_step) begin
                    w_state_nxt = COMMIT;
                end else begin
                    w_state_nxt = CONV_LO;
                end
            end
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Snapshot, repeated-subtraction converter and atomic digit commit
    always_ff @(posedge kh_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key        <= 15'h7FFF;
            r_pend       <= 1'b0;
            r_val        <= 6'd0;
            r_tens       <= 4'd0;
            r_cnt        <= 3'd0;
            r_lo_in      <= 6'd0;
            r_hi_t       <= 4'd0;
            r_hi_o       <= 4'd0;
            r_valid_pend <= 1'b1;
            r_colon_pend <= 1'b1;
            r_dig3       <= 4'd0;
            r_dig2       <= 4'd0;
            r_dig1       <= 4'd0;
            r_dig0       <= 4'd0;
            r_valid      <= 1'b1;
            r_colon      <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_key        <= w_key;
                        r_val        <= w_hi_val;
                        r_lo_in      <= w_lo_field;
                        r_valid_pend <= w_valid;
                        r_colon_pend <= w_colon;
                        r_tens       <= 4'd0;
                        r_cnt        <= 3'd0;
                        r_pend       <= 1'b1;
                        r_busy       <= 1'b1;
                    end else begin
                        r_pend <= 1'b0;
                    end
                end
                CONV_HI: begin
                    if (w_last_step) begin
                        r_hi_t <= w_tens_step;
                        r_hi_o <= w_val_step[3:0];
                        r_val  <= r_lo_in;
                        r_tens <= 4'd0;
                        r_cnt  <= 3'd0;
                    end else begin
                        r_val  <= w_val_step;
                        r_tens <= w_tens_step;
                        r_cnt  <= r_cnt + 3'd1;
                    end
                end
                CONV_LO: begin
                    r_val  <= w_val_step;
                    r_tens <= w_tens_step;
                    if (w_last_step) begin
                        r_cnt <= 3'd0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                COMMIT: begin
                    r_dig3  <= r_hi_t;
                    r_dig2  <= r_hi_o;
                    r_dig1  <= r_tens;
                    r_dig0  <= r_val[3:0];
                    r_valid <= r_valid_pend;
                    r_colon <= r_colon_pend;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_pend <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    // During COMMIT the scan reads the pending result so it lands with busy falling
    logic       w_commit;
    logic [3:0] w_src_dig;
    logic       w_src_valid;
    logic       w_src_colon;
    logic [3:0] w_an_nxt;
    logic [6:0] w_seg_nxt;
    logic       w_dp_nxt;

    assign w_commit    = (r_state == COMMIT);
    assign w_src_valid = w_commit ? r_valid_pend : r_valid;
    assign w_src_colon = w_commit ? r_colon_pend : r_colon;

    // Digit selection for the current scan slot
    always_comb begin
        w_src_dig = 4'd0;
        case (r_idx)
            2'd0:    w_src_dig = w_commit ? r_val[3:0] : r_dig0;
            2'd1:    w_src_dig = w_commit ? r_tens     : r_dig1;
            2'd2:    w_src_dig = w_commit ? r_hi_o     : r_dig2;
            2'd3:    w_src_dig = w_commit ? r_hi_t     : r_dig3;
            default: w_src_dig = 4'd0;
        endcase
    end

    assign w_an_nxt  = ~(4'b0001 << r_idx);
    assign w_seg_nxt = w_src_valid ? seg_encode(w_src_dig) : SEG_DASH;
    assign w_dp_nxt  = ~((r_idx == 2'd2) && w_src_colon);

    // Free-running scan and registered display pins
    always_ff @(posedge kh_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= 8'd0;
            r_idx <= 2'd0;
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
            if (r_div == DIV_LAST) begin
                r_div <= 8'd0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_div <= r_div + 8'd1;
            end
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign dp   = r_dp;
    assign busy = r_busy;

endmodule

// File: tb/tb_time_display_driver.sv
// Self-checking bench for time_display_driver: directed scenarios plus random
// time words compared against an arithmetic display model.
module tb_time_display_driver;

    logic        kh_clk = 1'b0;
    logic        reset_n;
    logic [26:0] disp_time;
    logic        sel_hm;
    logic        show_12;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [6:0]  seg_tab [10];
    logic [6:0]  exp_seg [4];
    logic        exp_colon;
    logic [14:0] prev_key;

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    time_display_driver #(.SCAN_DIV(1)) dut (
        .kh_clk    (kh_clk),
        .reset_n   (reset_n),
        .disp_time (disp_time),
        .sel_hm    (sel_hm),
        .show_12   (show_12),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .busy      (busy)
    );

    always #5 kh_clk = ~kh_clk;

    task automatic tick();
        @(posedge kh_clk);
        #1;
    endtask

    function automatic logic [14:0] key_of(input logic [4:0] h, input logic [5:0] m,
                                           input logic [5:0] s, input logic sel, input logic s12);
        logic [5:0] hi;
        logic [5:0] lo;
        hi = sel ? {1'b0, h} : m;
        lo = sel ? m : s;
        return {sel, s12, hi, lo, sel & s[0]};
    endfunction

    task automatic set_inputs(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                              input logic [9:0] ms, input logic sel, input logic s12);
        disp_time = {h, m, s, ms};
        sel_hm    = sel;
        show_12   = s12;
    endtask

    // Expected display for a time word, computed with plain decimal arithmetic
    task automatic model(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                         input logic sel, input logic s12);
        int  hi;
        int  lo;
        bit  ok;
        if (sel) begin
            hi = (s12 && h == 5'd0) ? 12 : int'(h);
            lo = int'(m);
            ok = (h <= 5'd23) && (m <= 6'd59);
            exp_colon = (s[0] == 1'b0);
        end else begin
            hi = int'(m);
            lo = int'(s);
            ok = (m <= 6'd59) && (s <= 6'd59);
            exp_colon = 1'b1;
        end
        exp_seg[3] = ok ? seg_tab[hi / 10] : DASH;
        exp_seg[2] = ok ? seg_tab[hi % 10] : DASH;
        exp_seg[1] = ok ? seg_tab[lo / 10] : DASH;
        exp_seg[0] = ok ? seg_tab[lo % 10] : DASH;
        prev_key = key_of(h, m, s, sel, s12);
    endtask

    task automatic apply(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                         input logic [9:0] ms, input logic sel, input logic s12);
        set_inputs(h, m, s, ms, sel, s12);
        model(h, m, s, sel, s12);
    endtask

    // Sample n consecutive scan slots: rotation order, segments, colon
    task automatic check_scan(input string name, input int n);
        logic [3:0] prev_an;
        logic [3:0] want_an;
        int         slot;
        prev_an = an;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                tick();
                want_an = (prev_an == 4'b0111) ? 4'b1110 : {prev_an[2:0], 1'b1};
                checks++;
                if (an !== want_an) begin
                    errors++;
                    $display("FAIL %s an_rotation: got %b want %b", name, an, want_an);
                end
            end
            case (an)
                4'b1110: slot = 0;
                4'b1101: slot = 1;
                4'b1011: slot = 2;
                4'b0111: slot = 3;
                default: slot = -1;
            endcase
            checks++;
            if (slot < 0) begin
                errors++;
                $display("FAIL %s an_onehot: got %b want one low bit", name, an);
            end else begin
                if (seg !== exp_seg[slot]) begin
                    errors++;
                    $display("FAIL %s seg_slot%0d: got %b want %b", name, slot, seg, exp_seg[slot]);
                end
                checks++;
                if (dp !== ~(slot == 2 && exp_colon)) begin
                    errors++;
                    $display("FAIL %s dp_slot%0d: got %b want %b", name, slot, dp,
                             ~(slot == 2 && exp_colon));
                end
            end
            prev_an = an;
        end
    endtask

    task automatic check_busy(input string name, input logic want);
        checks++;
        if (busy !== want) begin
            errors++;
            $display("FAIL %s busy: got %b want %b", name, busy, want);
        end
    endtask

    // Next edge latches the key: busy for 14 cycles, new digits on the 15th edge
    task automatic run_conv(input string name);
        tick();
        check_busy(name, 1'b1);
        repeat (13) begin
            tick();
            check_busy(name, 1'b1);
        end
        tick();
        check_busy(name, 1'b0);
        check_scan(name, 4);
    endtask

    task automatic check_blank(input string name);
        checks++;
        if (an !== 4'b1111 || seg !== BLANK || dp !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s blank: got an=%b seg=%b dp=%b busy=%b want 1111 1111111 1 0",
                     name, an, seg, dp, busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        apply(5'd0, 6'd0, 6'd0, 10'd0, 1'b0, 1'b0);
        repeat (3) tick();
        check_blank("reset_hold");
        reset_n = 1'b1;
        tick();
        checks++;
        if (an !== 4'b1110 || seg !== seg_tab[0]) begin
            errors++;
            $display("FAIL reset_first_edge: got an=%b seg=%b want 1110 %b", an, seg, seg_tab[0]);
        end
        check_busy("reset_first_edge", 1'b1);
        repeat (13) begin
            tick();
            check_busy("reset_conv", 1'b1);
        end
        tick();
        check_busy("reset_done", 1'b0);
        check_scan("reset_zero", 5);
    endtask

    task automatic test_mmss_and_ms_sweep();
        apply(5'd3, 6'd12, 6'd34, 10'd567, 1'b0, 1'b0);
        run_conv("mmss_1234");
        for (int i = 0; i < 20; i++) begin
            disp_time[9:0] = 10'($urandom_range(0, 999));
            tick();
            check_busy("ms_sweep", 1'b0);
        end
        disp_time[26:22] = 5'd17;
        tick();
        check_busy("hr_ignored_mmss", 1'b0);
        check_scan("mmss_hold", 4);
    endtask

    task automatic test_show12_colon();
        apply(5'd0, 6'd5, 6'd0, 10'd0, 1'b1, 1'b1);
        run_conv("hhmm_12_05");
        apply(5'd0, 6'd5, 6'd0, 10'd0, 1'b1, 1'b0);
        run_conv("hhmm_00_05");
        apply(5'd0, 6'd5, 6'd1, 10'd0, 1'b1, 1'b0);
        run_conv("hhmm_colon_off");
    endtask

    task automatic test_invalid();
        apply(5'd31, 6'd5, 6'd0, 10'd0, 1'b1, 1'b0);
        run_conv("invalid_hr31");
        apply(5'd23, 6'd59, 6'd58, 10'd0, 1'b1, 1'b0);
        run_conv("hhmm_23_59");
        apply(5'd24, 6'd0, 6'd0, 10'd0, 1'b1, 1'b0);
        run_conv("invalid_hr24");
        apply(5'd1, 6'd60, 6'd0, 10'd0, 1'b0, 1'b0);
        run_conv("invalid_min60");
        apply(5'd1, 6'd59, 6'd59, 10'd0, 1'b0, 1'b0);
        run_conv("mmss_59_59");
    endtask

    task automatic test_midchange();
        apply(5'd0, 6'd59, 6'd10, 10'd0, 1'b0, 1'b0);
        tick();
        check_busy("mid_latch", 1'b1);
        repeat (3) tick();
        set_inputs(5'd0, 6'd0, 6'd10, 10'd0, 1'b0, 1'b0);
        repeat (10) tick();
        check_busy("mid_old_conv", 1'b1);
        tick();
        check_busy("mid_old_done", 1'b0);
        check_scan("mid_old_value", 1);
        model(5'd0, 6'd0, 6'd10, 1'b0, 1'b0);
        run_conv("mid_new_value");
    endtask

    task automatic test_reset_mid();
        apply(5'd12, 6'd34, 6'd56, 10'd0, 1'b1, 1'b0);
        tick();
        repeat (7) tick();
        reset_n = 1'b0;
        #1;
        check_blank("reset_mid_async");
        tick();
        tick();
        check_blank("reset_mid_hold");
        reset_n = 1'b1;
        run_conv("reset_mid_recover");
    endtask

    task automatic test_random();
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       sel;
        logic       s12;
        for (int i = 0; i < 25; i++) begin
            h   = 5'($urandom_range(0, 31));
            m   = 6'($urandom_range(0, 63));
            s   = 6'($urandom_range(0, 63));
            sel = 1'($urandom_range(0, 1));
            s12 = 1'($urandom_range(0, 1));
            if (key_of(h, m, s, sel, s12) == prev_key) begin
                set_inputs(h, m, s, 10'($urandom_range(0, 999)), sel, s12);
                tick();
                check_busy("random_same_key", 1'b0);
            end else begin
                apply(h, m, s, 10'($urandom_range(0, 999)), sel, s12);
                run_conv("random");
            end
        end
    endtask

    initial begin
        seg_tab[0] = 7'b1000000;
        seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001;
        seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010;
        seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        reset_n   = 1'b0;
        disp_time = 27'd0;
        sel_hm    = 1'b0;
        show_12   = 1'b0;
        test_reset();
        test_mmss_and_ms_sweep();
        test_show12_colon();
        test_invalid();
        test_midchange();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_display_driver.md
# time_display_driver

Reader-side counterpart to the 12/24-hour timekeeping blocks. It consumes the packed 27-bit time word {hr[4:0], min[5:0], sec[5:0], ms[9:0]} and drives a 4-digit, common-anode, time-multiplexed 7-segment display. Binary-to-BCD conversion is sequential, and displayed digits update atomically. It sits between the clock core and the board display pins, in the same 1 kHz `kh_clk` domain.

## Interface
- SCAN_DIV, default 1: `kh_clk` cycles each digit stays enabled before the scan advances. Legal range is 1..255.
- kh_clk  input  1  single clock, 1 kHz tick domain.
- reset_n  input  1  asynchronous, active-low reset.
- disp_time  input  27  packed time word: hr [26:22], min [21:16], sec [15:10], ms [9:0].
- sel_hm  input  1  0 = show MM:SS; 1 = show HH:MM.
- show_12  input  1  1 = hour value 0 is displayed as "12".
- an  output  4  digit enables, active-low. an[0] is the rightmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low. Used as the colon.
- busy  output  1  high while a conversion is in flight.

## Operation
- Field pair (HI, LO): HH:MM when sel_hm=1, MM:SS when sel_hm=0. ms is never displayed and never triggers an update.
- Validity: the pair is invalid if hr>23, min>59 or sec>59 for any field in the selected pair. An invalid pair displays dash on all 4 digits (seg=7'b0111111).
- Hour mapping: if show_12=1 and hr=0, the HI value is 12.
- Snapshot key = {sel_hm, show_12, HI field, LO field, plus sec[0] when in HH:MM mode}.
- FSM states: IDLE, CONV_HI, CONV_LO, COMMIT.
  - IDLE: if the key differs from the stored key, latch key and fields, set busy=1, go to CONV_HI. Otherwise stay in IDLE.
  - CONV_HI: runs exactly 6 cycles. Each cycle, if val>=10 then val-=10 and tens+=1. After 6 cycles, remainder = ones.
  - CONV_LO: same as CONV_HI, for the LO field.
  - COMMIT: load the 4 digit registers and the valid flag in one cycle, clear busy, return to IDLE.
- Input changes during CONV_HI, CONV_LO or COMMIT are ignored. They are detected on return to IDLE.
- Digit mapping: an[3]=HI tens, an[2]=HI ones, an[1]=LO tens, an[0]=LO ones.
- Digit encoding uses the standard 0-9 patterns (0 → 7'b1000000, 1 → 7'b1111001, ..., 9 → 7'b0010000).
- Colon: dp=0 only while digit 2 is enabled.
  - MM:SS mode: colon always on.
  - HH:MM mode: colon on when the stored sec[0]=0.
- Scan: a 2-bit index advances 0→1→2→3→0 every SCAN_DIV cycles. The scan is free-running and independent of the FSM.

## Timing
- Reset (asserted, asynchronous):
  - Outputs: an=4'b1111, seg=7'b1111111, dp=1, busy=0.
  - Internal state: FSM=IDLE, digits=0, valid=1, scan index=0, stored key = all-ones sentinel, which forces a conversion on the first cycle after release.
- Reset deasserted:
  - First rising edge: an=4'b1110, showing the ones digit of LO from the reset digit registers, i.e. "0".
  - Same edge: IDLE detects the sentinel mismatch and goes to CONV_HI.
- Conversion latency: key latched at edge N. busy=1 from N through N+13. Digits visible on the scan from edge N+14, when busy=0 and the FSM is back in IDLE.
  - Breakdown: 1 latch cycle, 6 CONV_HI, 6 CONV_LO, 1 COMMIT.
- an, seg and dp are registered. All three change together on the scan edge, with no glitch between them.
- Digit registers change only at COMMIT. A scan never shows a mix of old and new digits within one digit slot.
- Reset asserted mid-conversion: busy=0 and display blank immediately. No partial commit occurs.
- Scan wrap: index 3→0 wraps with no extra idle cycle. The refresh period is 4×SCAN_DIV cycles.

## Test plan
- Reset then release with disp_time = 0, sel_hm=0: an=1111 during reset. After release, busy goes high for 14 cycles, then the scan shows "00:00" with an sequence 1110, 1101, 1011, 0111 and dp=0 only while an=1011.
- disp_time = hr 3, min 12, sec 34, ms 567, sel_hm=0: 14 cycles after key change, seg per an = 0111→'1', 1011→'2', 1101→'3', 1110→'4'. Sweeping ms alone never raises busy.
- sel_hm=1, show_12=1, hr=0, min=5: display "12:05". With show_12=0, display "00:05". Colon toggles with sec[0].
- hr=31 (underflow from season adjust), sel_hm=1: all four digits show seg=7'b0111111.
- Change min from 59 to 0 at cycle 3 of CONV_HI: the old value commits first; a second conversion starts on the first IDLE cycle; "00" appears 14 cycles later.
- Assert reset_n=0 at cycle 7 of a conversion: outputs blank immediately. After release, a fresh conversion runs and the correct value appears at cycle 14.
